// File: rtl/phy_sym_pkg.sv
// Lane symbol codes and framer state encoding shared by the TX framer and RX detector.
package phy_sym_pkg;

   localparam logic [7:0] COM  = 8'hBC;
   localparam logic [7:0] STP  = 8'hFB;
   localparam logic [7:0] SDP  = 8'h5C;
   localparam logic [7:0] SKP  = 8'h1C;
   localparam logic [7:0] END  = 8'hFD;
   localparam logic [7:0] EDB  = 8'hFE;
   localparam logic [7:0] FTS  = 8'h3C;
   localparam logic [7:0] IDLE = 8'h7C;

   // Each state names the context of the next symbol placed on the lane.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SKP  = 2'd1,
      ST_DATA = 2'd2,
      ST_END  = 2'd3
   } framer_state_e;

endpackage

// File: rtl/tx_symbol_framer_if.sv
// Packet source / lane bundle for tx_symbol_framer; in_abort exists only when TX_ABORT_EN is defined.
interface tx_symbol_framer_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;
`ifdef TX_ABORT_EN
   logic       in_abort;
`endif
   logic [7:0] tx_DataS;
   logic       tx_K;
   logic       tx_underrun;

`ifdef TX_ABORT_EN
   modport master (output in_valid, in_data, in_last, in_abort,
                   input  in_ready, tx_DataS, tx_K, tx_underrun);
   modport slave  (input  in_valid, in_data, in_last, in_abort,
                   output in_ready, tx_DataS, tx_K, tx_underrun);
`else
   modport master (output in_valid, in_data, in_last,
                   input  in_ready, tx_DataS, tx_K, tx_underrun);
   modport slave  (input  in_valid, in_data, in_last,
                   output in_ready, tx_DataS, tx_K, tx_underrun);
`endif
endinterface

// File: rtl/skp_timer.sv
// SKP ordered-set interval timer: raises skp_pend every SKP_INTERVAL enabled cycles until cleared.
module skp_timer #(
   parameter int SKP_INTERVAL = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic enb,
   input  logic clr,
   output logic skp_pend
);

   localparam int CNT_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);

   logic [CNT_W-1:0] cnt;
   logic             wrap;

   assign wrap = (cnt == CNT_LAST);

   // A wrap on the same edge as the COM that clears the request re-arms it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         skp_pend <= 1'b0;
      end else if (enb) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
         if (wrap)
            skp_pend <= 1'b1;
         else if (clr)
            skp_pend <= 1'b0;
      end
   end

endmodule

// File: rtl/tx_symbol_framer.sv
// TX symbol framer: wraps byte packets in STP/END, fills gaps with IDLE, inserts COM+SKP at boundaries.
// Optional build macro TX_ABORT_EN adds in_abort, which nullifies the packet with EDB.
module tx_symbol_framer
   import phy_sym_pkg::*;
#(
   parameter int SKP_INTERVAL = 64,
   parameter int SKP_LEN      = 3
) (
   input logic                clk,
   input logic                rst,
   input logic                enb,
   tx_symbol_framer_if.slave  lane
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_SKP  = ST_SKP;
   localparam logic [1:0] S_DATA = ST_DATA;
   localparam logic [1:0] S_END  = ST_END;

   logic [1:0] state;
   logic [2:0] skp_cnt;
   logic       skp_pend;
   logic       com_emit;
   logic       abort;

`ifdef TX_ABORT_EN
   assign abort = lane.in_abort;
`else
   assign abort = 1'b0;
`endif

   assign com_emit      = enb & (state == S_IDLE) & skp_pend;
   assign lane.in_ready = enb & (state == S_DATA);

   skp_timer #(
      .SKP_INTERVAL (SKP_INTERVAL)
   ) u_skp_timer (
      .clk      (clk),
      .rst      (rst),
      .enb      (enb),
      .clr      (com_emit),
      .skp_pend (skp_pend)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         skp_cnt          <= '0;
         lane.tx_DataS    <= IDLE;
         lane.tx_K        <= 1'b1;
         lane.tx_underrun <= 1'b0;
      end else if (enb) begin
         lane.tx_underrun <= 1'b0;
         lane.tx_K        <= 1'b1;
         case (state)
            S_IDLE: begin
               if (skp_pend) begin
                  lane.tx_DataS <= COM;
                  skp_cnt       <= 3'(SKP_LEN);
                  state         <= S_SKP;
               end else if (lane.in_valid) begin
                  lane.tx_DataS <= STP;
                  state         <= S_DATA;
               end else begin
                  lane.tx_DataS <= IDLE;
               end
            end
            S_SKP: begin
               lane.tx_DataS <= SKP;
               skp_cnt       <= skp_cnt - 1'b1;
               if (skp_cnt == 3'd1)
                  state <= S_IDLE;
            end
            S_DATA: begin
               if (lane.in_valid) begin
                  if (abort) begin
                     lane.tx_DataS <= EDB;
                     state         <= S_IDLE;
                  end else begin
                     lane.tx_DataS <= lane.in_data;
                     lane.tx_K     <= 1'b0;
                     if (lane.in_last)
                        state <= S_END;
                  end
               end else begin
                  // Source starved mid-packet: close it rather than stall the lane.
                  lane.tx_DataS    <= END;
                  lane.tx_underrun <= 1'b1;
                  state            <= S_IDLE;
               end
            end
            S_END: begin
               lane.tx_DataS <= END;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_symbol_framer.sv
// Bench for tx_symbol_framer: vector table, directed corner sequences, randomized run against a symbol-queue model.
module tb_tx_symbol_framer;
   import phy_sym_pkg::*;

   localparam int SKP_INTERVAL = 16;
   localparam int SKP_LEN      = 3;
`ifdef TX_ABORT_EN
   localparam bit HAS_ABORT = 1'b1;
`else
   localparam bit HAS_ABORT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic enb;

   tx_symbol_framer_if lane();

   tx_symbol_framer #(
      .SKP_INTERVAL (SKP_INTERVAL),
      .SKP_LEN      (SKP_LEN)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .enb  (enb),
      .lane (lane)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       e, v;
      logic [7:0] d;
      logic       l, a;
      logic [7:0] xd;
      logic       xk, xu, xr;
   } vec_t;

   vec_t tbl[24];

   // Reference model: symbols already committed to the lane, plus packet/SKP bookkeeping.
   logic [7:0] m_q[$];
   bit         m_in_pkt;
   bit         m_pend;
   int         m_ecount;
   logic [7:0] m_d;
   logic       m_k, m_u;

   function automatic vec_t mk(logic e, logic v, logic [7:0] d, logic l, logic a,
                               logic [7:0] xd, logic xk, logic xu, logic xr);
      vec_t r;
      r.e = e; r.v = v; r.d = d; r.l = l; r.a = a;
      r.xd = xd; r.xk = xk; r.xu = xu; r.xr = xr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic e, input logic v, input logic [7:0] d,
                         input logic l, input logic a);
      enb           = e;
      lane.in_valid = v;
      lane.in_data  = d;
      lane.in_last  = l;
`ifdef TX_ABORT_EN
      lane.in_abort = a;
`else
      if (a) begin end
`endif
   endtask

   // Apply one cycle of inputs and check in_ready before the edge and lane outputs after it.
   task automatic cyc(input logic e, input logic v, input logic [7:0] d, input logic l,
                      input logic a, input logic [7:0] xd, input logic xk,
                      input logic xu, input logic xr, input string tag);
      set_in(e, v, d, l, a);
      #1;
      chk({tag, " in_ready"}, 32'(lane.in_ready), 32'(xr));
      @(posedge clk);
      #1;
      chk({tag, " tx_DataS"}, 32'(lane.tx_DataS), 32'(xd));
      chk({tag, " tx_K"}, 32'(lane.tx_K), 32'(xk));
      chk({tag, " tx_underrun"}, 32'(lane.tx_underrun), 32'(xu));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_q.delete();
      m_in_pkt = 1'b0;
      m_pend   = 1'b0;
      m_ecount = 0;
      m_d = IDLE; m_k = 1'b1; m_u = 1'b0;
   endtask

   task automatic model_step(input logic e, input logic v, input logic [7:0] d,
                             input logic l, input logic a);
      if (e) begin
         m_u = 1'b0;
         m_k = 1'b1;
         if (m_q.size() > 0) begin
            m_d = m_q.pop_front();
         end else if (m_in_pkt) begin
            if (v) begin
               if (HAS_ABORT && a) begin
                  m_d = EDB;
                  m_in_pkt = 1'b0;
               end else begin
                  m_d = d;
                  m_k = 1'b0;
                  if (l) begin
                     m_in_pkt = 1'b0;
                     m_q.push_back(END);
                  end
               end
            end else begin
               m_d = END;
               m_u = 1'b1;
               m_in_pkt = 1'b0;
            end
         end else if (m_pend) begin
            m_d = COM;
            m_pend = 1'b0;
            repeat (SKP_LEN) m_q.push_back(SKP);
         end else if (v) begin
            m_d = STP;
            m_in_pkt = 1'b1;
         end else begin
            m_d = IDLE;
         end
         m_ecount++;
         if (m_ecount % SKP_INTERVAL == 0) m_pend = 1'b1;
      end
   endtask

   initial begin
      logic e, v, l, a, xr;
      logic [7:0] d;

      rst = 1'b1;
      set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Reset state and a quiet lane
      do_reset();
      chk("reset tx_DataS", 32'(lane.tx_DataS), 32'(IDLE));
      chk("reset tx_K", 32'(lane.tx_K), 32'd1);
      chk("reset tx_underrun", 32'(lane.tx_underrun), 32'd0);
      chk("reset in_ready", 32'(lane.in_ready), 32'd0);
      for (int i = 0; i < 10; i++)
         cyc(1, 0, 8'h00, 0, 0, IDLE, 1, 0, 0, "idle");

      // Vector table: normal packet, underrun, enb freeze, idle SKP insertion
      tbl[0]  = mk(1, 1, 8'h11, 0, 0, STP,   1, 0, 0);
      tbl[1]  = mk(1, 1, 8'h11, 0, 0, 8'h11, 0, 0, 1);
      tbl[2]  = mk(1, 1, 8'h22, 0, 0, 8'h22, 0, 0, 1);
      tbl[3]  = mk(1, 1, 8'h33, 1, 0, 8'h33, 0, 0, 1);
      tbl[4]  = mk(1, 0, 8'h00, 0, 0, END,   1, 0, 0);
      tbl[5]  = mk(1, 0, 8'h00, 0, 0, IDLE,  1, 0, 0);
      tbl[6]  = mk(1, 1, 8'hAA, 0, 0, STP,   1, 0, 0);
      tbl[7]  = mk(1, 1, 8'h11, 0, 0, 8'h11, 0, 0, 1);
      tbl[8]  = mk(1, 1, 8'h22, 0, 0, 8'h22, 0, 0, 1);
      tbl[9]  = mk(1, 0, 8'h00, 0, 0, END,   1, 1, 1);
      tbl[10] = mk(1, 0, 8'h00, 0, 0, IDLE,  1, 0, 0);
      tbl[11] = mk(1, 1, 8'h55, 0, 0, STP,   1, 0, 0);
      tbl[12] = mk(1, 1, 8'h55, 0, 0, 8'h55, 0, 0, 1);
      tbl[13] = mk(0, 1, 8'h66, 0, 0, 8'h55, 0, 0, 0);
      tbl[14] = mk(0, 0, 8'h00, 0, 0, 8'h55, 0, 0, 0);
      tbl[15] = mk(0, 1, 8'h66, 1, 0, 8'h55, 0, 0, 0);
      tbl[16] = mk(1, 1, 8'h66, 1, 0, 8'h66, 0, 0, 1);
      tbl[17] = mk(1, 0, 8'h00, 0, 0, END,   1, 0, 0);
      tbl[18] = mk(1, 0, 8'h00, 0, 0, IDLE,  1, 0, 0);
      tbl[19] = mk(1, 0, 8'h00, 0, 0, COM,   1, 0, 0);
      tbl[20] = mk(1, 0, 8'h00, 0, 0, SKP,   1, 0, 0);
      tbl[21] = mk(1, 0, 8'h00, 0, 0, SKP,   1, 0, 0);
      tbl[22] = mk(1, 0, 8'h00, 0, 0, SKP,   1, 0, 0);
      tbl[23] = mk(1, 0, 8'h00, 0, 0, IDLE,  1, 0, 0);
      do_reset();
      for (int i = 0; i < 24; i++)
         cyc(tbl[i].e, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].a,
             tbl[i].xd, tbl[i].xk, tbl[i].xu, tbl[i].xr, $sformatf("vec%0d", i));

      // Packet waiting while a SKP request is pending: ordered set goes first
      do_reset();
      for (int i = 0; i < 16; i++)
         cyc(1, 0, 8'h00, 0, 0, IDLE, 1, 0, 0, "wait idle");
      cyc(1, 1, 8'h01, 1, 0, COM, 1, 0, 0, "wait com");
      for (int i = 0; i < 3; i++)
         cyc(1, 1, 8'h01, 1, 0, SKP, 1, 0, 0, "wait skp");
      cyc(1, 1, 8'h01, 1, 0, STP,   1, 0, 0, "wait stp");
      cyc(1, 1, 8'h01, 1, 0, 8'h01, 0, 0, 1, "wait d");
      cyc(1, 0, 8'h00, 0, 0, END,   1, 0, 0, "wait end");
      cyc(1, 0, 8'h00, 0, 0, IDLE,  1, 0, 0, "wait idle2");

      // SKP request raised mid-packet is held until right after END
      do_reset();
      cyc(1, 1, 8'h00, 0, 0, STP, 1, 0, 0, "defer stp");
      for (int i = 0; i < 18; i++)
         cyc(1, 1, 8'(i + 8'h40), (i == 17), 0, 8'(i + 8'h40), 0, 0, 1, "defer d");
      cyc(1, 1, 8'h99, 0, 0, END, 1, 0, 0, "defer end");
      cyc(1, 1, 8'h99, 0, 0, COM, 1, 0, 0, "defer com");
      for (int i = 0; i < 3; i++)
         cyc(1, 1, 8'h99, 0, 0, SKP, 1, 0, 0, "defer skp");
      cyc(1, 1, 8'h99, 0, 0, STP,   1, 0, 0, "defer stp2");
      cyc(1, 1, 8'h99, 1, 0, 8'h99, 0, 0, 1, "defer d2");
      cyc(1, 0, 8'h00, 0, 0, END,   1, 0, 0, "defer end2");

      // Reset mid-packet: lane falls straight back to IDLE, no END
      do_reset();
      cyc(1, 1, 8'h12, 0, 0, STP,   1, 0, 0, "rstmid stp");
      cyc(1, 1, 8'h12, 0, 0, 8'h12, 0, 0, 1, "rstmid d");
      do_reset();
      chk("rstmid tx_DataS", 32'(lane.tx_DataS), 32'(IDLE));
      chk("rstmid in_ready", 32'(lane.in_ready), 32'd0);
      cyc(1, 0, 8'h00, 0, 0, IDLE, 1, 0, 0, "rstmid idle");

      // Abort with in_last also set: EDB when the feature is built in, plain data otherwise
      do_reset();
      cyc(1, 1, 8'h44, 0, 0, STP, 1, 0, 0, "abort stp");
`ifdef TX_ABORT_EN
      cyc(1, 1, 8'h44, 1, 1, EDB,  1, 0, 1, "abort edb");
      cyc(1, 0, 8'h00, 0, 0, IDLE, 1, 0, 0, "abort idle");
`else
      cyc(1, 1, 8'h44, 1, 1, 8'h44, 0, 0, 1, "abort data");
      cyc(1, 0, 8'h00, 0, 0, END,   1, 0, 0, "abort end");
`endif
      cyc(1, 0, 8'h00, 0, 0, IDLE, 1, 0, 0, "abort idle2");

      // Randomized run against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         e  = ($urandom % 8) != 0;
         v  = ($urandom % 6) != 0;
         d  = 8'($urandom);
         l  = ($urandom % 8) == 0;
         a  = ($urandom % 16) == 0;
         xr = e & m_in_pkt;
         model_step(e, v, d, l, a);
         cyc(e, v, d, l, a, m_d, m_k, m_u, xr, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
